// File: rtl/key_event_ctrl_pkg.sv
// Shared types and constants for the keypad event controller: FSM encoding,
// event layout and key count.
package key_event_ctrl_pkg;

    localparam int KEY_NUM = 16;
    localparam int KEV_W   = 5;

    typedef enum logic [1:0] {
        KEV_WAIT   = 2'd0,
        KEV_UPDATE = 2'd1,
        KEV_EMIT   = 2'd2
    } kev_state_t;

    typedef struct packed {
        logic       press;
        logic [3:0] code;
    } kev_t;

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through event FIFO. A push while full is still accepted when
// a pop frees a slot in the same cycle.
module key_event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_pop;
    logic             do_push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Keypad event controller: periodic sampling, per-key debounce, an ordered walk
// over all keys that queues press/release events into a FWFT FIFO.
module key_event_ctrl
    import key_event_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV = 100000,
    parameter int DEB_CNT    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] keys,
    output logic [15:0] pressed,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [3:0]  ev_code,
    output logic        ev_press,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic [1:0]  state_dbg
);

    // Handshake: an event transfers on any cycle where ev_valid & ev_ready;
    // ev_valid never drops and the head never changes until that transfer.

    localparam int               DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [3:0]       DEB_LAST = 4'(DEB_CNT);

    kev_state_t         state;
    kev_state_t         state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [KEY_NUM-1:0] samp_r;
    logic [KEY_NUM-1:0] chg;
    logic [3:0]         deb [KEY_NUM];
    logic [3:0]         idx;
    logic               samp_en;
    logic               upd_en;
    logic               emit_en;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               drop;
    kev_t               push_ev;
    kev_t               head_ev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign tick = enable & (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= KEV_WAIT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            KEV_WAIT:   if (tick) state_nxt = KEV_UPDATE;
            KEV_UPDATE: state_nxt = KEV_EMIT;
            KEV_EMIT:   if (idx == 4'd15) state_nxt = KEV_WAIT;
            default:    state_nxt = KEV_WAIT;
        endcase
    end

    always_comb begin
        samp_en = 1'b0;
        upd_en  = 1'b0;
        emit_en = 1'b0;
        case (state)
            KEV_WAIT:   samp_en = tick;
            KEV_UPDATE: upd_en  = 1'b1;
            KEV_EMIT:   emit_en = 1'b1;
            default:    ;
        endcase
    end

    assign state_dbg = state;

    // A flip is only latched in chg during UPDATE; the EMIT walk applies it so
    // events leave in ascending key order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_r  <= '0;
            chg     <= '0;
            pressed <= '0;
            idx     <= '0;
            for (int i = 0; i < KEY_NUM; i++) deb[i] <= '0;
        end else begin
            if (samp_en) samp_r <= keys;
            if (upd_en) begin
                idx <= '0;
                for (int i = 0; i < KEY_NUM; i++) begin
                    if (samp_r[i] == pressed[i]) begin
                        deb[i] <= '0;
                    end else if (deb[i] + 4'd1 == DEB_LAST) begin
                        deb[i] <= '0;
                        chg[i] <= 1'b1;
                    end else begin
                        deb[i] <= deb[i] + 4'd1;
                    end
                end
            end
            if (emit_en) begin
                idx <= idx + 4'd1;
                if (chg[idx]) begin
                    chg[idx]     <= 1'b0;
                    pressed[idx] <= ~pressed[idx];
                end
            end
        end
    end

    assign push          = emit_en & chg[idx];
    assign push_ev.press = ~pressed[idx];
    assign push_ev.code  = idx;
    assign pop           = ev_valid & ev_ready;
    assign drop          = push & full & ~pop;

    key_event_fifo #(
        .WIDTH (KEV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_ev),
        .full  (full),
        .pop   (pop),
        .dout  (head_ev),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    // Head fields read zero when nothing is queued, matching the reset view.
    assign ev_valid = ~empty;
    assign ev_code  = empty ? 4'd0 : head_ev.code;
    assign ev_press = empty ? 1'b0 : head_ev.press;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with SAMPLE_DIV=32, DEB_CNT=3, FIFO_DEPTH=4.
module tb_key_event_ctrl;
    import key_event_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] keys;
    logic [15:0] pressed;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_code;
    logic        ev_press;
    logic        overflow;
    logic        ovf_clr;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_event_ctrl #(
        .SAMPLE_DIV (32),
        .DEB_CNT    (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .keys      (keys),
        .pressed   (pressed),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_press  (ev_press),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .state_dbg (state_dbg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (state_dbg == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (ev_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic get_event(input int max_cyc, output bit ok, output logic [3:0] code,
                             output logic press);
        ok = 1'b0; code = '0; press = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (ev_valid) begin
                code = ev_code; press = ev_press;
                ev_ready = 1'b1;
                step();
                ev_ready = 1'b0;
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit seen;
        rst = 1'b0; enable = 1'b1; keys = 16'h0001; ev_ready = 1'b0; ovf_clr = 1'b0;
        repeat (5) step();
        checks++; if (pressed !== 16'h0) begin failures++; $display("FAIL rst_pressed got=%h want=0000", pressed); end
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", ev_valid); end
        checks++; if ({ev_code, ev_press} !== 5'h0) begin failures++; $display("FAIL rst_head got code=%0d press=%b want 0/0", ev_code, ev_press); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b want=0", overflow); end
        rst = 1'b1;
        // Ticks at cycles 32/64/96, third UPDATE at 97, push of key 0 at 98.
        cyc = 0; seen = 1'b0;
        while (cyc < 200 && !seen) begin
            step(); cyc++;
            seen = ev_valid;
        end
        checks++; if (cyc !== 98) begin failures++; $display("FAIL first_ev_latency got=%0d want=98", cyc); end
        checks++; if ({ev_code, ev_press} !== {4'd0, 1'b1}) begin failures++; $display("FAIL first_ev got code=%0d press=%b want 0/1", ev_code, ev_press); end
        checks++; if (pressed !== 16'h0001) begin failures++; $display("FAIL first_pressed got=%h want=0001", pressed); end
        ev_ready = 1'b1; step(); ev_ready = 1'b0;
        repeat (40) step();
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL single_event got valid=%b want=0", ev_valid); end
    endtask

    task automatic test_bounce();
        bit ok;
        logic [3:0] c; logic p;
        for (int t = 0; t < 10; t++) begin
            wait_state(2'(KEV_UPDATE), 100, ok);
            checks++; if (!ok) begin failures++; $display("FAIL bounce_tick_timeout got=0 want=1"); end
            keys[5] = ~keys[5];
        end
        keys[5] = 1'b0;
        repeat (20) step();
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL bounce_no_event got valid=%b want=0", ev_valid); end
        checks++; if (pressed !== 16'h0001) begin failures++; $display("FAIL bounce_pressed got=%h want=0001", pressed); end
        keys[5] = 1'b1;
        get_event(6 * 32 + 40, ok, c, p);
        checks++; if (!ok || c !== 4'd5 || p !== 1'b1) begin failures++; $display("FAIL bounce_hold_ev got ok=%0d code=%0d press=%b want 5/1", ok, c, p); end
        keys = 16'h0;
        get_event(5 * 32 + 40, ok, c, p);
        checks++; if (!ok || c !== 4'd0 || p !== 1'b0) begin failures++; $display("FAIL rel0_ev got ok=%0d code=%0d press=%b want 0/0", ok, c, p); end
        get_event(40, ok, c, p);
        checks++; if (!ok || c !== 4'd5 || p !== 1'b0) begin failures++; $display("FAIL rel5_ev got ok=%0d code=%0d press=%b want 5/0", ok, c, p); end
    endtask

    task automatic test_order_release();
        bit ok;
        logic [3:0] c; logic p;
        logic [3:0] exp_code [3];
        exp_code[0] = 4'd0; exp_code[1] = 4'd4; exp_code[2] = 4'd15;
        keys = 16'h8011;
        for (int k = 0; k < 3; k++) begin
            get_event(5 * 32 + 40, ok, c, p);
            checks++; if (!ok || c !== exp_code[k] || p !== 1'b1) begin failures++; $display("FAIL order_press[%0d] got ok=%0d code=%0d press=%b want %0d/1", k, ok, c, p, exp_code[k]); end
        end
        checks++; if (pressed !== 16'h8011) begin failures++; $display("FAIL order_pressed got=%h want=8011", pressed); end
        keys = 16'h0;
        for (int k = 0; k < 3; k++) begin
            get_event(5 * 32 + 40, ok, c, p);
            checks++; if (!ok || c !== exp_code[k] || p !== 1'b0) begin failures++; $display("FAIL order_release[%0d] got ok=%0d code=%0d press=%b want %0d/0", k, ok, c, p, exp_code[k]); end
        end
        checks++; if (pressed !== 16'h0) begin failures++; $display("FAIL release_pressed got=%h want=0000", pressed); end
    endtask

    task automatic test_overflow();
        bit ok;
        int n;
        logic [3:0] c; logic p;
        ev_ready = 1'b0;
        keys = 16'h003F;
        n = 0;
        while (n < 6 * 32 && pressed !== 16'h003F) begin step(); n++; end
        step(); step();
        checks++; if (pressed !== 16'h003F) begin failures++; $display("FAIL ovf_pressed got=%h want=003f", pressed); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", overflow); end
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b want=0", overflow); end
        for (int k = 0; k < 4; k++) begin
            get_event(10, ok, c, p);
            checks++; if (!ok || c !== 4'(k) || p !== 1'b1) begin failures++; $display("FAIL ovf_queued[%0d] got ok=%0d code=%0d press=%b want %0d/1", k, ok, c, p, k); end
        end
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL ovf_dropped got valid=%b code=%0d want valid=0", ev_valid, ev_code); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit stable;
        int n;
        logic [3:0] c; logic p;
        ev_ready = 1'b0;
        keys = 16'h0020;
        wait_valid(6 * 32 + 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_first_timeout got=0 want=1"); end
        // Pushes of keys 1..3 follow on consecutive edges; the FIFO is full after the third.
        stable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (ev_valid !== 1'b1 || ev_code !== 4'd0 || ev_press !== 1'b0) stable = 1'b0;
        end
        checks++; if (!stable) begin failures++; $display("FAIL b2b_head_stable got code=%0d press=%b want 0/0", ev_code, ev_press); end
        ev_ready = 1'b1; step(); ev_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b want=0", overflow); end
        stable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (ev_valid !== 1'b1 || ev_code !== 4'd1 || ev_press !== 1'b0) stable = 1'b0;
        end
        checks++; if (!stable) begin failures++; $display("FAIL b2b_head_hold got code=%0d press=%b want 1/0", ev_code, ev_press); end
        n = 0;
        for (int k = 1; k <= 4; k++) begin
            get_event(10, ok, c, p);
            if (ok) n++;
            checks++; if (!ok || c !== 4'(k) || p !== 1'b0) begin failures++; $display("FAIL b2b_ev[%0d] got ok=%0d code=%0d press=%b want %0d/0", k, ok, c, p, k); end
        end
        checks++; if (ev_valid !== 1'b0 || n !== 4) begin failures++; $display("FAIL b2b_count got=%0d valid=%b want=4 valid=0", n, ev_valid); end
        checks++; if (pressed !== 16'h0020) begin failures++; $display("FAIL b2b_pressed got=%h want=0020", pressed); end
    endtask

    task automatic test_reset_mid_emit_enable();
        bit ok;
        logic [3:0] c; logic p;
        keys = 16'h0027;
        wait_valid(6 * 32 + 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_first_timeout got=0 want=1"); end
        // Walk is at idx 1 now; six more edges reach idx 7 with keys 0..2 queued.
        repeat (6) step();
        checks++; if (state_dbg !== 2'(KEV_EMIT)) begin failures++; $display("FAIL mid_state got=%0d want=%0d", state_dbg, KEV_EMIT); end
        rst = 1'b0;
        #1;
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b want=0", ev_valid); end
        checks++; if (pressed !== 16'h0) begin failures++; $display("FAIL mid_rst_pressed got=%h want=0000", pressed); end
        checks++; if (state_dbg !== 2'(KEV_WAIT)) begin failures++; $display("FAIL mid_rst_state got=%0d want=%0d", state_dbg, KEV_WAIT); end
        repeat (3) step();
        keys = 16'h0003;
        rst = 1'b1;
        wait_valid(4 * 32 + 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL post_rst_timeout got=0 want=1"); end
        repeat (20) step();
        enable = 1'b0;
        keys = 16'h0100;
        repeat (5 * 32) step();
        checks++; if (pressed !== 16'h0003 || state_dbg !== 2'(KEV_WAIT)) begin failures++; $display("FAIL frozen got pressed=%h state=%0d want 0003/0", pressed, state_dbg); end
        for (int k = 0; k < 2; k++) begin
            get_event(10, ok, c, p);
            checks++; if (!ok || c !== 4'(k) || p !== 1'b1) begin failures++; $display("FAIL drain[%0d] got ok=%0d code=%0d press=%b want %0d/1", k, ok, c, p, k); end
        end
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL frozen_no_event got valid=%b code=%0d want=0", ev_valid, ev_code); end
        enable = 1'b1;
        get_event(5 * 32 + 40, ok, c, p);
        checks++; if (!ok || c !== 4'd0 || p !== 1'b0) begin failures++; $display("FAIL resume_ev got ok=%0d code=%0d press=%b want 0/0", ok, c, p); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_order_release();
        test_overflow();
        test_back_to_back();
        test_reset_mid_emit_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
